// File: rtl/aes_pkg.sv
// Shared types, widths and byte S-box arithmetic for the
// time-multiplexed S-box scheduler.
package aes_pkg;

    localparam int STATE_W  = 128;
    localparam int WORD_W   = 32;
    localparam int NUM_COLS = 4;

    typedef enum logic {
        IDLE,
        BUSY
    } sched_state_t;

    typedef enum logic [1:0] {
        NONE,
        KEY,
        STATE
    } grant_t;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    // Forward AES S-box: field inverse then affine transform.
    function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i
             ^ {i[6:0], i[7]}
             ^ {i[5:0], i[7:6]}
             ^ {i[4:0], i[7:5]}
             ^ {i[3:0], i[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox_word.sv
// One 32-bit S-box lane: four independent byte S-boxes,
// purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    assign byte_o = sbox_fwd(byte_i);

endmodule

module sbox_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [WORD_W-1:0] word_o
);

    for (genvar b = 0; b < WORD_W / 8; b++) begin : g_byte
        aes_sbox u_sbox (
            .byte_i (word_i[8*b +: 8]),
            .byte_o (word_o[8*b +: 8])
        );
    end

endmodule

// File: rtl/sbox_scheduler.sv
// Shares one 32-bit S-box lane between a 4-beat state job
// and single key-expansion words, with registered results.
module sbox_scheduler
    import aes_pkg::*;
#(
    parameter logic ALTERNATE = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sb_valid,
    output logic               sb_ready,
    input  logic [STATE_W-1:0] sb_state,
    output logic               sb_out_valid,
    output logic [STATE_W-1:0] sb_out_state,
    input  logic               kw_valid,
    output logic               kw_ready,
    input  logic [WORD_W-1:0]  kw_word,
    output logic               kw_out_valid,
    output logic [WORD_W-1:0]  kw_out_word
);

    localparam int BEAT_W = $clog2(NUM_COLS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_COLS - 1);

    sched_state_t      state_q;
    grant_t            last_grant_q;
    logic [BEAT_W-1:0] beat_q;
    logic [STATE_W-1:0] job_q;
    logic [STATE_W-1:0] res_q;
    logic [STATE_W-1:0] res_d;
    logic               sb_out_valid_q;
    logic [STATE_W-1:0] sb_out_state_q;
    logic               kw_out_valid_q;
    logic [WORD_W-1:0]  kw_out_word_q;

    grant_t            grant;
    logic [WORD_W-1:0] job_col;
    logic [WORD_W-1:0] lane_in;
    logic [WORD_W-1:0] lane_out;

    // Lane arbitration: key words only compete while a job runs.
    always_comb begin
        grant = NONE;
        if (state_q == IDLE) begin
            if (kw_valid) grant = KEY;
        end else if (!kw_valid) begin
            grant = STATE;
        end else if (ALTERNATE) begin
            grant = (last_grant_q == STATE) ? KEY : STATE;
        end else begin
            grant = KEY;
        end
    end

    // Pick the current column of the job, MSB column first.
    always_comb begin
        job_col = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (beat_q == BEAT_W'(c))
                job_col = job_q[STATE_W-1-WORD_W*c -: WORD_W];
        end
    end

    assign lane_in = (grant == KEY) ? kw_word : job_col;

    sbox_word u_lane (
        .word_i (lane_in),
        .word_o (lane_out)
    );

    // Merge the substituted column into the result image.
    always_comb begin
        res_d = res_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (beat_q == BEAT_W'(c))
                res_d[STATE_W-1-WORD_W*c -: WORD_W] = lane_out;
        end
    end

    // Scheduler FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            last_grant_q   <= STATE;
            beat_q         <= '0;
            job_q          <= '0;
            res_q          <= '0;
            sb_out_valid_q <= 1'b0;
            sb_out_state_q <= '0;
            kw_out_valid_q <= 1'b0;
            kw_out_word_q  <= '0;
        end else begin
            sb_out_valid_q <= 1'b0;
            kw_out_valid_q <= (grant == KEY);
            if (grant == KEY) kw_out_word_q <= lane_out;
            if (grant != NONE) last_grant_q <= grant;
            unique case (state_q)
                IDLE: begin
                    if (sb_valid) begin
                        job_q   <= sb_state;
                        res_q   <= '0;
                        beat_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (grant == STATE) begin
                        res_q  <= res_d;
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            sb_out_state_q <= res_d;
                            sb_out_valid_q <= 1'b1;
                            state_q        <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign sb_ready     = (state_q == IDLE);
    assign kw_ready     = (grant == KEY);
    assign sb_out_valid = sb_out_valid_q;
    assign sb_out_state = sb_out_state_q;
    assign kw_out_valid = kw_out_valid_q;
    assign kw_out_word  = kw_out_word_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed bench for sbox_scheduler: one instance alternating,
// one with key-first arbitration.
module tb_sbox_scheduler;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         a_sb_valid, a_sb_ready, a_sb_out_valid;
    logic         a_kw_valid, a_kw_ready, a_kw_out_valid;
    logic [127:0] a_sb_state, a_sb_out_state;
    logic [31:0]  a_kw_word, a_kw_out_word;

    logic         b_sb_valid, b_sb_ready, b_sb_out_valid;
    logic         b_kw_valid, b_kw_ready, b_kw_out_valid;
    logic [127:0] b_sb_state, b_sb_out_state;
    logic [31:0]  b_kw_word, b_kw_out_word;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] V_IN  = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V_OUT = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] Z_OUT = {16{8'h63}};
    localparam logic [127:0] F_IN  = {16{8'hff}};
    localparam logic [127:0] F_OUT = {16{8'h16}};

    logic [31:0] kw_in[3]  = '{32'hcf4f3c09, 32'h00000000, 32'h10203040};
    logic [31:0] kw_exp[3] = '{32'h8a84eb01, 32'h63636363, 32'hcab70409};

    sbox_scheduler #(.ALTERNATE(1'b1)) dut_alt (
        .clk          (clk),
        .rst_n        (rst_n),
        .sb_valid     (a_sb_valid),
        .sb_ready     (a_sb_ready),
        .sb_state     (a_sb_state),
        .sb_out_valid (a_sb_out_valid),
        .sb_out_state (a_sb_out_state),
        .kw_valid     (a_kw_valid),
        .kw_ready     (a_kw_ready),
        .kw_word      (a_kw_word),
        .kw_out_valid (a_kw_out_valid),
        .kw_out_word  (a_kw_out_word)
    );

    sbox_scheduler #(.ALTERNATE(1'b0)) dut_key (
        .clk          (clk),
        .rst_n        (rst_n),
        .sb_valid     (b_sb_valid),
        .sb_ready     (b_sb_ready),
        .sb_state     (b_sb_state),
        .sb_out_valid (b_sb_out_valid),
        .sb_out_state (b_sb_out_state),
        .kw_valid     (b_kw_valid),
        .kw_ready     (b_kw_ready),
        .kw_word      (b_kw_word),
        .kw_out_valid (b_kw_out_valid),
        .kw_out_word  (b_kw_out_word)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        a_sb_valid = 0; a_sb_state = '0; a_kw_valid = 0; a_kw_word = '0;
        b_sb_valid = 0; b_sb_state = '0; b_kw_valid = 0; b_kw_word = '0;
        tick;
        tick;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        do_reset;
        rst_n = 1'b0;
        a_kw_valid = 1'b1;
        tick;
        total++;
        if (a_sb_ready !== 1'b1) begin
            bad++; $display("FAIL reset_sb_ready got=%b want=1", a_sb_ready);
        end
        total++;
        if (a_kw_ready !== 1'b1) begin
            bad++; $display("FAIL reset_kw_ready got=%b want=1", a_kw_ready);
        end
        total++;
        if ({a_sb_out_valid, a_kw_out_valid, b_sb_out_valid, b_kw_out_valid} !== 4'b0) begin
            bad++; $display("FAIL reset_out_valid got=%b%b%b%b want=0000",
                            a_sb_out_valid, a_kw_out_valid, b_sb_out_valid, b_kw_out_valid);
        end
        total++;
        if (a_sb_out_state !== '0 || a_kw_out_word !== '0) begin
            bad++; $display("FAIL reset_out_data got=%h/%h want=0/0", a_sb_out_state, a_kw_out_word);
        end
        a_kw_valid = 1'b0;
        #1;
        total++;
        if (a_kw_ready !== 1'b0 || b_sb_ready !== 1'b1) begin
            bad++; $display("FAIL reset_idle_ready got=%b/%b want=0/1", a_kw_ready, b_sb_ready);
        end
        rst_n = 1'b1;
        tick;
        total++;
        if (a_sb_ready !== 1'b1 || a_sb_out_valid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset got=%b/%b want=1/0", a_sb_ready, a_sb_out_valid);
        end
    endtask

    task automatic test_reset_midjob;
        logic seen;
        a_sb_valid = 1'b1;
        a_sb_state = V_IN;
        tick;
        a_sb_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        total++;
        if (a_sb_ready !== 1'b1 || a_sb_out_state !== '0) begin
            bad++; $display("FAIL midjob_reset got=%b/%h want=1/0", a_sb_ready, a_sb_out_state);
        end
        tick;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (a_sb_out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL midjob_no_result got=%b want=0", seen);
        end
    endtask

    task automatic test_state_job;
        do_reset;
        a_sb_valid = 1'b1;
        a_sb_state = V_IN;
        #1;
        total++;
        if (a_sb_ready !== 1'b1) begin
            bad++; $display("FAIL job_accept_ready got=%b want=1", a_sb_ready);
        end
        tick;
        a_sb_valid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick;
            total++;
            if (a_sb_out_valid !== (e == 4) || a_sb_ready !== (e == 4)) begin
                bad++; $display("FAIL job_edge%0d got=v%b r%b want=%b", e,
                                a_sb_out_valid, a_sb_ready, e == 4);
            end
        end
        total++;
        if (a_sb_out_state !== V_OUT) begin
            bad++; $display("FAIL job_data got=%h want=%h", a_sb_out_state, V_OUT);
        end
        tick;
        total++;
        if (a_sb_out_valid !== 1'b0) begin
            bad++; $display("FAIL job_pulse_len got=%b want=0", a_sb_out_valid);
        end
    endtask

    task automatic test_key_word;
        a_kw_valid = 1'b1;
        a_kw_word  = kw_in[0];
        #1;
        total++;
        if (a_kw_ready !== 1'b1) begin
            bad++; $display("FAIL key_ready got=%b want=1", a_kw_ready);
        end
        tick;
        a_kw_valid = 1'b0;
        total++;
        if (a_kw_out_valid !== 1'b1 || a_kw_out_word !== kw_exp[0]) begin
            bad++; $display("FAIL key_out got=%b/%h want=1/%h", a_kw_out_valid, a_kw_out_word, kw_exp[0]);
        end
        tick;
        total++;
        if (a_kw_out_valid !== 1'b0) begin
            bad++; $display("FAIL key_pulse_len got=%b want=0", a_kw_out_valid);
        end
    endtask

    task automatic test_contention_alt;
        int idx;
        logic kr;
        logic exp_kr;
        do_reset;
        a_sb_valid = 1'b1;
        a_sb_state = V_IN;
        tick;
        a_sb_valid = 1'b0;
        idx = 0;
        a_kw_valid = 1'b1;
        a_kw_word  = kw_in[0];
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_kr = (c < 6) && (c % 2 == 0);
            kr = a_kw_ready;
            total++;
            if (kr !== exp_kr) begin
                bad++; $display("FAIL alt_grant c%0d got=%b want=%b", c, kr, exp_kr);
            end
            tick;
            total++;
            if (a_kw_out_valid !== kr || (kr === 1'b1 && a_kw_out_word !== kw_exp[idx])) begin
                bad++; $display("FAIL alt_key c%0d got=%b/%h want=%b/%h", c,
                                a_kw_out_valid, a_kw_out_word, kr, kw_exp[idx]);
            end
            if (kr === 1'b1 && idx < 3) idx++;
            a_kw_valid = (idx < 3);
            a_kw_word  = kw_in[(idx < 3) ? idx : 0];
            total++;
            if (a_sb_out_valid !== (c + 1 == 7)) begin
                bad++; $display("FAIL alt_done e%0d got=%b want=%b", c + 1, a_sb_out_valid, c + 1 == 7);
            end
            if (c + 1 == 7) begin
                total++;
                if (a_sb_out_state !== V_OUT) begin
                    bad++; $display("FAIL alt_data got=%h want=%h", a_sb_out_state, V_OUT);
                end
            end
        end
        total++;
        if (idx !== 3) begin
            bad++; $display("FAIL alt_key_count got=%0d want=3", idx);
        end
    endtask

    task automatic test_contention_key_first;
        int idx;
        logic kr;
        logic exp_kr;
        b_sb_valid = 1'b1;
        b_sb_state = V_IN;
        tick;
        b_sb_valid = 1'b0;
        idx = 0;
        b_kw_valid = 1'b1;
        b_kw_word  = kw_in[0];
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_kr = (c < 3);
            kr = b_kw_ready;
            total++;
            if (kr !== exp_kr) begin
                bad++; $display("FAIL kf_grant c%0d got=%b want=%b", c, kr, exp_kr);
            end
            tick;
            total++;
            if (b_kw_out_valid !== kr || (kr === 1'b1 && b_kw_out_word !== kw_exp[idx])) begin
                bad++; $display("FAIL kf_key c%0d got=%b/%h want=%b/%h", c,
                                b_kw_out_valid, b_kw_out_word, kr, kw_exp[idx]);
            end
            if (kr === 1'b1 && idx < 3) idx++;
            b_kw_valid = (idx < 3);
            b_kw_word  = kw_in[(idx < 3) ? idx : 0];
            total++;
            if (b_sb_out_valid !== (c + 1 == 7)) begin
                bad++; $display("FAIL kf_done e%0d got=%b want=%b", c + 1, b_sb_out_valid, c + 1 == 7);
            end
            if (c + 1 == 7) begin
                total++;
                if (b_sb_out_state !== V_OUT) begin
                    bad++; $display("FAIL kf_data got=%h want=%h", b_sb_out_state, V_OUT);
                end
            end
        end
        total++;
        if (idx !== 3) begin
            bad++; $display("FAIL kf_key_count got=%0d want=3", idx);
        end
    endtask

    task automatic test_simultaneous_idle;
        do_reset;
        a_sb_valid = 1'b1;
        a_sb_state = '0;
        a_kw_valid = 1'b1;
        a_kw_word  = kw_in[0];
        #1;
        total++;
        if (a_sb_ready !== 1'b1 || a_kw_ready !== 1'b1) begin
            bad++; $display("FAIL sim_ready got=%b/%b want=1/1", a_sb_ready, a_kw_ready);
        end
        tick;
        a_sb_valid = 1'b0;
        a_kw_word  = kw_in[1];
        #1;
        total++;
        if (a_kw_out_valid !== 1'b1 || a_kw_out_word !== kw_exp[0] || a_kw_ready !== 1'b0) begin
            bad++; $display("FAIL sim_first got=%b/%h/r%b want=1/%h/r0",
                            a_kw_out_valid, a_kw_out_word, a_kw_ready, kw_exp[0]);
        end
        tick;
        total++;
        if (a_kw_out_valid !== 1'b0 || a_kw_ready !== 1'b1) begin
            bad++; $display("FAIL sim_beat0 got=%b/r%b want=0/r1", a_kw_out_valid, a_kw_ready);
        end
        tick;
        a_kw_valid = 1'b0;
        total++;
        if (a_kw_out_valid !== 1'b1 || a_kw_out_word !== kw_exp[1]) begin
            bad++; $display("FAIL sim_second got=%b/%h want=1/%h", a_kw_out_valid, a_kw_out_word, kw_exp[1]);
        end
        for (int e = 3; e <= 5; e++) begin
            tick;
            total++;
            if (a_sb_out_valid !== (e == 5)) begin
                bad++; $display("FAIL sim_done e%0d got=%b want=%b", e, a_sb_out_valid, e == 5);
            end
        end
        total++;
        if (a_sb_out_state !== Z_OUT) begin
            bad++; $display("FAIL sim_data got=%h want=%h", a_sb_out_state, Z_OUT);
        end
    endtask

    task automatic test_back_to_back;
        a_sb_valid = 1'b1;
        a_sb_state = '0;
        tick;
        a_sb_valid = 1'b0;
        repeat (4) tick;
        total++;
        if (a_sb_out_valid !== 1'b1 || a_sb_out_state !== Z_OUT || a_sb_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_first got=%b/%h/r%b want=1/%h/r1",
                            a_sb_out_valid, a_sb_out_state, a_sb_ready, Z_OUT);
        end
        a_sb_valid = 1'b1;
        a_sb_state = F_IN;
        tick;
        a_sb_valid = 1'b0;
        total++;
        if (a_sb_out_valid !== 1'b0 || a_sb_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_accept got=%b/r%b want=0/r0", a_sb_out_valid, a_sb_ready);
        end
        for (int e = 1; e <= 4; e++) begin
            tick;
            total++;
            if (a_sb_out_valid !== (e == 4)) begin
                bad++; $display("FAIL b2b_done e%0d got=%b want=%b", e, a_sb_out_valid, e == 4);
            end
        end
        total++;
        if (a_sb_out_state !== F_OUT) begin
            bad++; $display("FAIL b2b_data got=%h want=%h", a_sb_out_state, F_OUT);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_reset_midjob;
        test_state_job;
        test_key_word;
        test_contention_alt;
        test_contention_key_first;
        test_simultaneous_idle;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
